// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the PLC scan program-counter sequencer.
// PC_SEQ_WATCHDOG_EN adds the FAULT state to the state encoding.
package pc_sequencer_pkg;

    localparam int unsigned PC_W  = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned WDT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
`ifdef PC_SEQ_WATCHDOG_EN
        ,
        ST_FAULT = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/pc_incr.sv
// 4-bit ripple incrementer feeding the program counter's +1 path.
module pc_incr
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] i_a,
    output logic [PC_W-1:0] o_sum_c
);

    logic w_c1;
    logic w_c2;

    // Ripple carries: each bit toggles when all lower bits are one
    assign w_c1       = i_a[0] & i_a[1];
    assign w_c2       = w_c1 & i_a[2];
    assign o_sum_c[0] = ~i_a[0];
    assign o_sum_c[1] = i_a[0] ^ i_a[1];
    assign o_sum_c[2] = w_c1 ^ i_a[2];
    assign o_sum_c[3] = w_c2 ^ i_a[3];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for one PLC scan: IDLE -> RUN -> DONE -> IDLE.
// Define PC_SEQ_WATCHDOG_EN to add the RUN-time watchdog and the sticky FAULT state.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned SCAN_LAST = 15,
    parameter int unsigned WDT_LIMIT = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stall,
    input  logic             i_jump_valid,
    input  logic [PC_W-1:0]  i_jump_addr,
    output logic             o_jump_ready_c,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_pc_valid,
    output logic             o_scan_done,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_scan_count,
    output logic             o_fault
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_LAST);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    w_pc_inc;
    logic [CNT_W-1:0]   r_scan_count;
    logic [CNT_W-1:0]   w_scan_count_nxt;
    logic               r_pc_valid;
    logic               r_scan_done;
    logic               r_busy;
    logic               w_pc_valid_nxt;
    logic               w_scan_done_nxt;
    logic               w_busy_nxt;
    logic               w_advance;

    pc_incr u_pc_incr (
        .i_a     (r_pc),
        .o_sum_c (w_pc_inc)
    );

    // A running, unstalled cycle is the only one that moves the program counter
    assign w_advance = (r_state == ST_RUN) && !i_stall;

`ifdef PC_SEQ_WATCHDOG_EN
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);

    logic [WDT_W-1:0] r_wdt;
    logic [WDT_W-1:0] w_wdt_nxt;
    logic             w_wdt_hit;
    logic             r_fault;

    assign w_wdt_nxt = r_wdt + WDT_W'(1);
    assign w_wdt_hit = (r_state == ST_RUN) && (w_wdt_nxt == WDT_MAX);

    // Watchdog: cleared while waiting in IDLE, counts every RUN cycle including stalls
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wdt   <= '0;
            r_fault <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_wdt <= '0;
            end else if (r_state == ST_RUN) begin
                r_wdt <= w_wdt_nxt;
            end
            r_fault <= (w_state_nxt == ST_FAULT);
        end
    end

    assign o_fault = r_fault;
`else
    logic w_unused_wdt;

    assign w_unused_wdt = ^WDT_W'(WDT_LIMIT);
    assign o_fault      = 1'b0;
`endif

    // State register; reset overrides every other input
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a jump on the last address keeps the scan running
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef PC_SEQ_WATCHDOG_EN
                if (w_wdt_hit) begin
                    w_state_nxt = ST_FAULT;
                end else
`endif
                if (w_advance && !i_jump_valid && (r_pc == PC_LAST)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the next state
    always_comb begin
        w_pc_nxt         = r_pc;
        w_scan_count_nxt = r_scan_count;
        if (w_advance) begin
            if (i_jump_valid) begin
                w_pc_nxt = i_jump_addr;
            end else if (r_pc != PC_LAST) begin
                w_pc_nxt = w_pc_inc;
            end
        end
        if (r_state == ST_DONE) begin
            w_scan_count_nxt = r_scan_count + CNT_W'(1);
        end
        if (w_state_nxt != ST_RUN) begin
            w_pc_nxt = '0;
        end
        w_pc_valid_nxt  = (w_state_nxt == ST_RUN);
        w_scan_done_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt      = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
    end

    // Output and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= '0;
            r_scan_count <= '0;
            r_pc_valid   <= 1'b0;
            r_scan_done  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_scan_count <= w_scan_count_nxt;
            r_pc_valid   <= w_pc_valid_nxt;
            r_scan_done  <= w_scan_done_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign o_jump_ready_c = w_advance;
    assign o_pc           = r_pc;
    assign o_pc_valid     = r_pc_valid;
    assign o_scan_done    = r_scan_done;
    assign o_busy         = r_busy;
    assign o_scan_count   = r_scan_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer.
// Instance 0: SCAN_LAST=5; instance 1: SCAN_LAST=2; instance 2: SCAN_LAST=5, WDT_LIMIT=10.
module tb_pc_sequencer;

    typedef struct packed {
        logic [3:0] pc;
        logic       pv;
        logic       sd;
        logic       bsy;
        logic [7:0] cnt;
        logic       flt;
        logic       jr;
    } obs_t;

    typedef struct {
        string       tag;
        int unsigned dut;
        obs_t        exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst   [3];
    logic       start [3];
    logic       stall [3];
    logic       jv    [3];
    logic [3:0] ja    [3];
    logic       jr    [3];
    logic [3:0] pc    [3];
    logic       pv    [3];
    logic       sd    [3];
    logic       bsy   [3];
    logic [7:0] cnt   [3];
    logic       flt   [3];

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.SCAN_LAST(5), .WDT_LIMIT(64)) u_dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_start(start[0]), .i_stall(stall[0]),
        .i_jump_valid(jv[0]), .i_jump_addr(ja[0]), .o_jump_ready_c(jr[0]),
        .o_pc(pc[0]), .o_pc_valid(pv[0]), .o_scan_done(sd[0]), .o_busy(bsy[0]),
        .o_scan_count(cnt[0]), .o_fault(flt[0])
    );

    pc_sequencer #(.SCAN_LAST(2), .WDT_LIMIT(64)) u_dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_start(start[1]), .i_stall(stall[1]),
        .i_jump_valid(jv[1]), .i_jump_addr(ja[1]), .o_jump_ready_c(jr[1]),
        .o_pc(pc[1]), .o_pc_valid(pv[1]), .o_scan_done(sd[1]), .o_busy(bsy[1]),
        .o_scan_count(cnt[1]), .o_fault(flt[1])
    );

    pc_sequencer #(.SCAN_LAST(5), .WDT_LIMIT(10)) u_dut2 (
        .i_clk(clk), .i_reset(rst[2]), .i_start(start[2]), .i_stall(stall[2]),
        .i_jump_valid(jv[2]), .i_jump_addr(ja[2]), .o_jump_ready_c(jr[2]),
        .o_pc(pc[2]), .o_pc_valid(pv[2]), .o_scan_done(sd[2]), .o_busy(bsy[2]),
        .o_scan_count(cnt[2]), .o_fault(flt[2])
    );

    function automatic obs_t observe(input int unsigned d);
        obs_t o;
        o = {pc[d], pv[d], sd[d], bsy[d], cnt[d], flt[d], jr[d]};
        return o;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push the expected post-edge view, advance one edge, pop and compare
    task automatic step(input string tag, input int unsigned d, input int e_pc, input int e_pv,
                        input int e_sd, input int e_bsy, input int e_cnt, input int e_flt,
                        input int e_jr);
        sb_t  e;
        obs_t act;
        e.tag = tag;
        e.dut = d;
        e.exp = {4'(e_pc), 1'(e_pv), 1'(e_sd), 1'(e_bsy), 8'(e_cnt), 1'(e_flt), 1'(e_jr)};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        act = observe(e.dut);
        checks++;
        assert (act === e.exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed pc=%0d pv=%b sd=%b busy=%b cnt=%0d fault=%b jr=%b expected pc=%0d pv=%b sd=%b busy=%b cnt=%0d fault=%b jr=%b",
                   e.tag, e.dut, act.pc, act.pv, act.sd, act.bsy, act.cnt, act.flt, act.jr,
                   e.exp.pc, e.exp.pv, e.exp.sd, e.exp.bsy, e.exp.cnt, e.exp.flt, e.exp.jr);
        end
    endtask

    task automatic s_run(input string tag, input int unsigned d, input int p, input int c, input int j);
        step(tag, d, p, 1, 0, 1, c, 0, j);
    endtask

    task automatic s_done(input string tag, input int unsigned d, input int c);
        step(tag, d, 0, 0, 1, 1, c, 0, 0);
    endtask

    task automatic s_idle(input string tag, input int unsigned d, input int c);
        step(tag, d, 0, 0, 0, 0, c, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; stall[i] = 1'b0; jv[i] = 1'b0; ja[i] = 4'd0;
        end
        tick(1);
        s_idle("reset0", 0, 0);
        s_idle("reset1", 1, 0);
        s_idle("reset2", 2, 0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Basic scan with SCAN_LAST=5
        start[0] = 1'b1;
        s_run("basic_pc0", 0, 0, 0, 1);
        start[0] = 1'b0;
        for (int p = 1; p <= 5; p++) s_run("basic_pc", 0, p, 0, 1);
        s_done("basic_done", 0, 0);
        s_idle("basic_idle", 0, 1);

        // Stall at Pc=2 for three cycles; a jump offered during the stall is not taken
        start[0] = 1'b1;
        s_run("stall_pc0", 0, 0, 1, 1);
        start[0] = 1'b0;
        s_run("stall_pc1", 0, 1, 1, 1);
        s_run("stall_pc2", 0, 2, 1, 1);
        stall[0] = 1'b1; jv[0] = 1'b1; ja[0] = 4'd9;
        for (int k = 0; k < 3; k++) s_run("stall_hold", 0, 2, 1, 0);
        stall[0] = 1'b0; jv[0] = 1'b0;
        s_run("stall_release", 0, 3, 1, 1);

        // Jumps: backward jump at Pc=4, and a jump on the last address suppresses ScanDone
        s_run("jump_pc4", 0, 4, 1, 1);
        jv[0] = 1'b1; ja[0] = 4'd1;
        s_run("jump_back", 0, 1, 1, 1);
        jv[0] = 1'b0;
        for (int p = 2; p <= 5; p++) s_run("jump_walk", 0, p, 1, 1);
        jv[0] = 1'b1; ja[0] = 4'd0;
        s_run("jump_at_last", 0, 0, 1, 1);
        jv[0] = 1'b0;
        for (int p = 1; p <= 5; p++) s_run("jump_rescan", 0, p, 1, 1);
        s_done("jump_done", 0, 1);
        s_idle("jump_idle", 0, 2);

        // Start held high: one scan every SCAN_LAST+3 = 8 cycles
        start[0] = 1'b1;
        tick(7);
        s_idle("period1", 0, 3);
        tick(7);
        start[0] = 1'b0;
        s_idle("period2", 0, 4);

        // Reset mid-scan at Pc=3 wins over Start and JumpValid
        start[0] = 1'b1;
        s_run("mid_pc0", 0, 0, 4, 1);
        start[0] = 1'b0;
        for (int p = 1; p <= 3; p++) s_run("mid_pc", 0, p, 4, 1);
        rst[0] = 1'b1; start[0] = 1'b1; jv[0] = 1'b1; ja[0] = 4'd7;
        s_idle("reset_mid", 0, 0);
        rst[0] = 1'b0; start[0] = 1'b0; jv[0] = 1'b0;
        s_idle("reset_after", 0, 0);

        // Wrap with SCAN_LAST=2: jump to 14 counts through 15 and 0 up to 2
        start[1] = 1'b1;
        s_run("wrap_pc0", 1, 0, 0, 1);
        start[1] = 1'b0; jv[1] = 1'b1; ja[1] = 4'd14;
        s_run("wrap_pc14", 1, 14, 0, 1);
        jv[1] = 1'b0;
        s_run("wrap_pc15", 1, 15, 0, 1);
        s_run("wrap_pc0b", 1, 0, 0, 1);
        s_run("wrap_pc1", 1, 1, 0, 1);
        s_run("wrap_pc2", 1, 2, 0, 1);
        s_done("wrap_done", 1, 0);
        s_idle("wrap_idle", 1, 1);

        // 254 back-to-back scans of 5 cycles bring ScanCount to 255, the next one wraps it
        start[1] = 1'b1;
        tick(254 * 5 - 1);
        start[1] = 1'b0;
        s_idle("preload_255", 1, 255);
        start[1] = 1'b1;
        s_run("cwrap_pc0", 1, 0, 255, 1);
        start[1] = 1'b0;
        s_run("cwrap_pc1", 1, 1, 255, 1);
        s_run("cwrap_pc2", 1, 2, 255, 1);
        s_done("cwrap_done", 1, 255);
        s_idle("count_wrap", 1, 0);

        // Watchdog with WDT_LIMIT=10: Start, then Stall held high
        start[2] = 1'b1;
        s_run("wdt_run1", 2, 0, 0, 1);
        start[2] = 1'b0; stall[2] = 1'b1;
        for (int k = 2; k <= 10; k++) s_run("wdt_stall", 2, 0, 0, 0);
`ifdef PC_SEQ_WATCHDOG_EN
        step("wdt_fault", 2, 0, 0, 0, 0, 0, 1, 0);
        stall[2] = 1'b0; start[2] = 1'b1;
        for (int k = 0; k < 3; k++) step("wdt_start_ignored", 2, 0, 0, 0, 0, 0, 1, 0);
        start[2] = 1'b0;
`else
        for (int k = 0; k < 20; k++) s_run("nowdt_stall", 2, 0, 0, 0);
        stall[2] = 1'b0;
        s_run("nowdt_release", 2, 1, 0, 1);
`endif
        rst[2] = 1'b1;
        s_idle("wdt_reset", 2, 0);
        rst[2] = 1'b0;
        s_idle("wdt_after_reset", 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
